bcd_updown_counter: RTL and testbench

//  Multi-digit BCD up/down counter; sits directly downstream of the clock divider.

---
 rtl/bcd_pkg.sv | 33 +++
 rtl/bcd_digit.sv | 44 ++++
 rtl/bcd_updown_counter.sv | 106 ++++++++++
 tb/tb_bcd_updown_counter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the BCD up/down counter.
// BCD_SEG7_EN adds the seven-segment decode helper.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;
    localparam logic       DIR_UP  = 1'b1;
    localparam logic       DIR_DN  = 1'b0;

`ifdef BCD_SEG7_EN
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    // Active-low {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
    function automatic logic [6:0] seg7_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction
`endif

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: load (non-BCD loads as 0) has priority over a step up or down.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       up_dn,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       carry_out,
    output logic       borrow_out
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = (ld_val > BCD_MAX) ? BCD_MIN : ld_val;
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
            end else begin
                q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= BCD_MIN;
        end else begin
            q_q <= q_d;
        end
    end

    assign q          = q_q;
    assign carry_out  = (q_q == BCD_MAX) && (up_dn == DIR_UP);
    assign borrow_out = (q_q == BCD_MIN) && (up_dn == DIR_DN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter advanced by rising edges of the divider output.
// BCD_SEG7_EN adds a registered active-low seven-segment output per digit.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_div,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  wrap
`ifdef BCD_SEG7_EN
    ,
    output logic [7*DIGITS-1:0]   seg
`endif
);

    localparam int unsigned CW = 4 * DIGITS;

    logic              clk_div_q;
    logic              tick;
    logic              wrap_q;
    logic              wrap_d;
    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] borrow;
    logic [CW-1:0]     count_w;

    // Reset high so a divider already high at reset release yields no tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_div_q <= 1'b1;
        end else begin
            clk_div_q <= clk_div;
        end
    end

    assign tick    = clk_div & ~clk_div_q;
    assign step[0] = tick & en;

    for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
        if (i > 0) begin : g_ripple
            assign step[i] = step[i-1] & (carry[i-1] | borrow[i-1]);
        end
        bcd_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .step       (step[i]),
            .up_dn      (up_dn),
            .ld         (load),
            .ld_val     (load_val[4*i +: 4]),
            .q          (count_w[4*i +: 4]),
            .carry_out  (carry[i]),
            .borrow_out (borrow[i])
        );
    end

    // Wrap is the MSD carry/borrow actually taken; a load suppresses it.
    always_comb begin
        wrap_d = 1'b0;
        if (!load) begin
            wrap_d = step[DIGITS-1] & (carry[DIGITS-1] | borrow[DIGITS-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign count = count_w;
    assign wrap  = wrap_q;
    assign tc    = (&carry) | (&borrow);

`ifdef BCD_SEG7_EN
    logic [7*DIGITS-1:0] seg_q;
    logic [7*DIGITS-1:0] seg_d;

    always_comb begin
        seg_d = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            seg_d[7*i +: 7] = seg7_decode(count_w[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= {DIGITS{SEG_ZERO}};
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg = seg_q;
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomized and directed bench for bcd_updown_counter against an integer-valued model.
module tb_bcd_updown_counter;

    localparam int DIGITS = 4;
    localparam int MAXV   = 9999;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_div = 1'b1;
    logic        en = 1'b0;
    logic        up_dn = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic [15:0] count;
    logic        tc;
    logic        wrap;
`ifdef BCD_SEG7_EN
    logic [27:0] seg;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    int m_val = 0;
    int m_seg_src = 0;
    bit m_wrap = 1'b0;
    bit m_prev = 1'b1;
    bit m_tick;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    bcd_updown_counter #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_div  (clk_div),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap)
`ifdef BCD_SEG7_EN
        ,
        .seg      (seg)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int load_to_int(input logic [15:0] lv);
        int v;
        int p;
        int d;
        v = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 0;
            v = v + d * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic logic [27:0] seg_of(input int v);
        logic [27:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[7*i +: 7] = seg_tab[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counter value as a plain integer modulo 10^DIGITS.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_val = 0;
            m_wrap = 1'b0;
            m_prev = 1'b1;
            m_seg_src = 0;
        end else begin
            m_tick = clk_div & ~m_prev;
            m_prev = clk_div;
            m_seg_src = m_val;
            m_wrap = 1'b0;
            if (load) begin
                m_val = load_to_int(load_val);
            end else if (m_tick && en) begin
                if (up_dn) begin
                    if (m_val == MAXV) begin
                        m_val = 0;
                        m_wrap = 1'b1;
                    end else begin
                        m_val = m_val + 1;
                    end
                end else begin
                    if (m_val == 0) begin
                        m_val = MAXV;
                        m_wrap = 1'b1;
                    end else begin
                        m_val = m_val - 1;
                    end
                end
            end
        end
    end

    // Cycle compare, away from the active edge and from input changes.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("count", 32'(count), 32'(to_bcd(m_val)));
            check("wrap", 32'(wrap), 32'(m_wrap));
            check("tc", 32'(tc), 32'(up_dn ? (m_val == MAXV) : (m_val == 0)));
`ifdef BCD_SEG7_EN
            check("seg", 32'(seg), 32'(seg_of(m_seg_src)));
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        clk_div = 1'b0;
        cyc(1);
        clk_div = 1'b1;
        cyc(1);
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        load_val = v;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        // 1: reset with clk_div already high, no false tick
        cyc(3);
        rst = 1'b0;
        chk_en = 1'b1;
        en = 1'b1;
        up_dn = 1'b1;
        cyc(3);
        check("lit_reset_count", 32'(count), 32'h0000);
        check("lit_reset_wrap", 32'(wrap), 32'h0);
        do_tick();
        check("lit_first_tick", 32'(count), 32'h0001);

        // 2: carry ripple and up wrap
        do_load(16'h0099);
        do_tick();
        check("lit_0099_up", 32'(count), 32'h0100);
        check("lit_0099_wrap", 32'(wrap), 32'h0);
        do_load(16'h9999);
        clk_div = 1'b0;
        cyc(1);
        check("lit_tc_9999", 32'(tc), 32'h1);
        clk_div = 1'b1;
        cyc(1);
        check("lit_up_wrap_count", 32'(count), 32'h0000);
        check("lit_up_wrap_pulse", 32'(wrap), 32'h1);
        cyc(1);
        check("lit_up_wrap_clear", 32'(wrap), 32'h0);

        // 3: borrow and down wrap
        up_dn = 1'b0;
        do_load(16'h0000);
        do_tick();
        check("lit_dn_wrap_count", 32'(count), 32'h9999);
        check("lit_dn_wrap_pulse", 32'(wrap), 32'h1);
        do_load(16'h1000);
        do_tick();
        check("lit_1000_dn", 32'(count), 32'h0999);

        // 4: load beats a simultaneous tick; hex digit loads as 0
        clk_div = 1'b0;
        cyc(1);
        clk_div = 1'b1;
        load = 1'b1;
        load_val = 16'h12F4;
        cyc(1);
        load = 1'b0;
        check("lit_load_sanitize", 32'(count), 32'h1204);
        cyc(2);
        check("lit_tick_dropped", 32'(count), 32'h1204);

        // 5: enable low loses ticks; async reset mid-run
        en = 1'b0;
        repeat (3) begin
            clk_div = 1'b0;
            cyc(2);
            clk_div = 1'b1;
            cyc(2);
        end
        check("lit_en_low_hold", 32'(count), 32'h1204);
        en = 1'b1;
        up_dn = 1'b1;
        do_load(16'h9999);
        clk_div = 1'b0;
        cyc(1);
        clk_div = 1'b1;
        cyc(1);
        #1 rst = 1'b1;
        #1;
        check("lit_async_rst_count", 32'(count), 32'h0000);
        check("lit_async_rst_wrap", 32'(wrap), 32'h0);
        cyc(2);
        rst = 1'b0;
        cyc(2);

`ifdef BCD_SEG7_EN
        // 6: segment decode lags count by one cycle
        do_load(16'h0007);
        check("lit_seg_count7", 32'(count), 32'h0007);
        cyc(1);
        check("lit_seg_lsd7", 32'(seg[6:0]), 32'(7'b1111000));
        check("lit_seg_upper0", 32'(seg[27:7]), 32'({3{7'b1000000}}));
`endif

        // Randomized phase
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 2) == 0) clk_div = ~clk_div;
            en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
            load = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0: load_val = 16'h9999;
                1: load_val = 16'h0000;
                default: load_val = 16'($urandom);
            endcase
            if ($urandom_range(0, 999) == 0) begin
                #2 rst = 1'b1;
                cyc(1);
                rst = 1'b0;
            end else begin
                cyc(1);
            end
        end
        load = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
